// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: reset PC, exception vector,
// FSM state encoding and the NOP word.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    localparam logic [1:0] ST_REQ    = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_CANCEL = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush clears, load captures, stall holds,
// otherwise a bubble (valid=0, instr=NOP) is inserted while the PC is kept.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        adel_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        adel_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        adel_q, adel_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        adel_d  = adel_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            adel_d  = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
            adel_d  = adel_i;
        end else if (!stall_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            adel_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            adel_q  <= adel_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;
    assign adel_o  = adel_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: single-outstanding fetch FSM, PC redirect and IF/ID.
// Optional fetch alignment check enabled by defining IF_ADEL_CHECK_EN.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_pc_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        id_adel
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] buf_q, buf_d;
    logic        drop_q, drop_d;
    logic [31:0] fetch_addr;
    logic        misaligned;
    logic        adel_fire;
    logic        adel_take;
    logic        accept;
    logic        id_load;
    logic [31:0] id_load_instr;
    logic        id_load_adel;

`ifdef IF_ADEL_CHECK_EN
    logic adel_done_q;

    assign fetch_addr = pc_q;
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign adel_fire  = misaligned && !adel_done_q;

    // One faulting bubble per bad PC; only a flush re-arms the check.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            adel_done_q <= 1'b0;
        end else if (adel_take) begin
            adel_done_q <= 1'b1;
        end
    end
`else
    assign fetch_addr = {pc_q[31:2], 2'b00};
    assign misaligned = 1'b0;
    assign adel_fire  = 1'b0;
`endif

    assign inst_req  = !rst && (state_q == ST_REQ) && !drop_q && !misaligned;
    assign inst_addr = fetch_addr;
    assign accept    = inst_req && inst_addr_ok;
    assign adel_take = (state_q == ST_REQ) && adel_fire && !stall_i && !flush_i && !drop_q;

    always_comb begin
        pc_d = pc_q;
        if (accept) begin
            pc_d = seq_pc(fetch_addr);
        end
        if (flush_i) begin
            pc_d = flush_pc_i;
        end else if (branch_i && !misaligned) begin
            pc_d = branch_pc_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_pc_d      = req_pc_q;
        buf_d         = buf_q;
        drop_d        = drop_q && !inst_data_ok;
        id_load       = 1'b0;
        id_load_instr = inst_rdata;
        id_load_adel  = 1'b0;
        if (accept) begin
            req_pc_d = fetch_addr;
        end
        case (state_q)
            ST_REQ: begin
                if (accept) begin
                    state_d = flush_i ? ST_CANCEL : ST_WAIT;
                end else if (adel_take) begin
                    id_load       = 1'b1;
                    id_load_instr = NOP_INSTR;
                    id_load_adel  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (inst_data_ok) begin
                    if (flush_i) begin
                        state_d = ST_REQ;
                    end else if (!stall_i) begin
                        id_load = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        buf_d   = inst_rdata;
                        state_d = ST_HOLD;
                    end
                end else if (flush_i) begin
                    state_d = ST_CANCEL;
                end
            end
            ST_CANCEL: begin
                if (inst_data_ok) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                if (flush_i) begin
                    state_d = ST_REQ;
                end else if (!stall_i) begin
                    id_load       = 1'b1;
                    id_load_instr = buf_q;
                    state_d       = ST_REQ;
                end
            end
        endcase
    end

    // A reset that lands while a response is outstanding leaves a stale
    // data_ok in flight; remember it so the next request waits it out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0;
            buf_q    <= NOP_INSTR;
            drop_q   <= (drop_q || state_q == ST_WAIT || state_q == ST_CANCEL) && !inst_data_ok;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            buf_q    <= buf_d;
            drop_q   <= drop_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .stall_i (stall_i),
        .load_i  (id_load),
        .instr_i (id_load_instr),
        .pc_i    (adel_take ? pc_q : req_pc_q),
        .adel_i  (id_load_adel),
        .instr_o (id_instr),
        .pc_o    (id_pc),
        .valid_o (id_valid),
        .adel_o  (id_adel)
    );

endmodule
